motion_update_broadcast_arbiter: RTL and testbench

MOTION_UPDATE_BROADCAST_ARBITER -- requirements
Module: motion_update_broadcast_arbiter

---
 rtl/motion_update_broadcast_arbiter_pkg.sv | 23 ++
 rtl/motion_update_broadcast_arbiter_rr_arbiter.sv | 63 ++++++
 rtl/motion_update_broadcast_arbiter.sv | 148 ++++++++++++++
 tb/tb_motion_update_broadcast_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_update_broadcast_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// motion_update_broadcast_arbiter_pkg
// Shared definitions for the motion-update broadcast path: FSM state
// encodings, the default settle length, and a small index-width helper.
// -----------------------------------------------------------------------------
package motion_update_broadcast_arbiter_pkg;

    // FSM state encodings, kept as plain constants for legacy compatibility.
    localparam int         STATE_W   = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Cycles with enable low before the pass is reported complete.
    localparam int DEFAULT_SETTLE_CYCLES = 3;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/motion_update_broadcast_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin one-hot arbiter. The search starts one past the most recently
// granted requester; the grant pointer only moves when a grant is issued.
//
// Ports
//   clk    in   clock
//   rst    in   synchronous active-high reset (pointer -> NUM_REQ-1)
//   en     in   arbitration enable; grant is all zero when low
//   req    in   NUM_REQ request vector
//   grant  out  NUM_REQ one-hot grant (combinational)
// -----------------------------------------------------------------------------
module rr_arbiter
    import motion_update_broadcast_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every variable gets a default before any conditional assignment,
    // so no path through the block leaves a value held (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        cand      = last_grant;
        found     = 1'b0;
        if (en) begin
            // Offsets 1..NUM_REQ visit every requester once, ending on the
            // previous winner, so the last winner has lowest priority.
            for (int off = 1; off <= NUM_REQ; off++) begin
                cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant_idx   = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (found) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/motion_update_broadcast_arbiter.sv
// -----------------------------------------------------------------------------
// motion_update_broadcast_arbiter
// Arbitrates NUM_REQ motion-update requesters onto a single broadcast bus for
// the duration of one pass. A pass runs from start until every requester has
// reported done and no data is pending, then waits SETTLE_CYCLES with enable
// low and pulses update_done.
//
// Ports
//   clk                   in   clock
//   rst                   in   synchronous active-high reset
//   start                 in   begin a pass (sampled only in IDLE)
//   req_valid             in   NUM_REQ per-requester valid
//   req_data              in   NUM_REQ x {vz,vy,vx} particle words
//   req_dst_cell          in   NUM_REQ x {cell_x,cell_y,cell_z} destinations
//   req_done              in   NUM_REQ requester finished for this pass
//   req_ready             out  NUM_REQ one-hot grant, only in RUN
//   motion_update_enable  out  registered, high exactly while in RUN
//   out_data              out  broadcast particle word (0 when not valid)
//   out_data_dst_cell     out  broadcast destination (0 when not valid)
//   out_data_valid        out  broadcast valid, one cycle after transfer
//   busy                  out  state is not IDLE
//   update_done           out  high for the single DONE cycle
//   broadcast_count       out  saturating transfer count for the pass
// -----------------------------------------------------------------------------
module motion_update_broadcast_arbiter
    import motion_update_broadcast_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   req_dst_cell,
    input  logic [NUM_REQ-1:0]                   req_done,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]              out_data,
    output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
    output logic                                 out_data_valid,
    output logic                                 busy,
    output logic                                 update_done,
    output logic [CNT_WIDTH-1:0]                 broadcast_count
);

    localparam int PW  = 3 * DATA_WIDTH;
    localparam int CW  = 3 * CELL_ID_WIDTH;
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [NUM_REQ-1:0] done_sticky;
    logic [SCW-1:0]     settle_cnt;
    logic [NUM_REQ-1:0] grant;
    logic               in_run;
    logic               xfer;
    logic               all_done;
    logic               pass_start;
    logic [PW-1:0]      sel_data;
    logic [CW-1:0]      sel_dst;

    assign in_run     = (state == ST_RUN);
    assign pass_start = (state == ST_IDLE) && start;
    assign xfer       = |grant;
    assign req_ready  = grant;
    assign busy       = (state != ST_IDLE);
    assign update_done = (state == ST_DONE);

    // A done raised this cycle counts immediately, so a pass where everyone
    // is done on the first RUN cycle holds enable for exactly one cycle.
    assign all_done = &(done_sticky | req_done);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .en    (in_run),
        .req   (req_valid),
        .grant (grant)
    );

    // One-hot grant turns the data select into an AND-OR mux; zero when idle.
    always_comb begin
        sel_data = '0;
        sel_dst  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | req_data[i*PW +: PW];
                sel_dst  = sel_dst  | req_dst_cell[i*CW +: CW];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_RUN;
            ST_RUN:    if (all_done && (req_valid == '0)) next_state = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            motion_update_enable <= 1'b0;
            out_data             <= '0;
            out_data_dst_cell    <= '0;
            out_data_valid       <= 1'b0;
            done_sticky          <= '0;
            settle_cnt           <= '0;
            broadcast_count      <= '0;
        end else begin
            state                <= next_state;
            motion_update_enable <= (next_state == ST_RUN);
            out_data             <= sel_data;
            out_data_dst_cell    <= sel_dst;
            out_data_valid       <= xfer;

            if (pass_start) begin
                done_sticky <= '0;
            end else if (in_run) begin
                done_sticky <= done_sticky | req_done;
            end

            if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + SCW'(1);
            end else begin
                settle_cnt <= '0;
            end

            if (pass_start) begin
                broadcast_count <= '0;
            end else if (xfer && (broadcast_count != {CNT_WIDTH{1'b1}})) begin
                broadcast_count <= broadcast_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_motion_update_broadcast_arbiter.sv
// -----------------------------------------------------------------------------
// tb_motion_update_broadcast_arbiter
// Self-checking bench: a table of per-cycle arbitration vectors plus directed
// sequences for pass completion, reset and start handling. Expected broadcast
// words are queued when a grant is expected and compared when the DUT emits.
// -----------------------------------------------------------------------------
module tb_motion_update_broadcast_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int CIW     = 4;
    localparam int PW      = 3 * DW;
    localparam int CW      = 3 * CIW;
    localparam int CNTW    = 16;
    localparam int SETTLE  = 3;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PW-1:0]     req_data;
    logic [NUM_REQ*CW-1:0]     req_dst_cell;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      motion_update_enable;
    logic [PW-1:0]             out_data;
    logic [CW-1:0]             out_data_dst_cell;
    logic                      out_data_valid;
    logic                      busy;
    logic                      update_done;
    logic [CNTW-1:0]           broadcast_count;

    motion_update_broadcast_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_WIDTH    (DW),
        .CELL_ID_WIDTH (CIW),
        .SETTLE_CYCLES (SETTLE),
        .CNT_WIDTH     (CNTW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_dst_cell         (req_dst_cell),
        .req_done             (req_done),
        .req_ready            (req_ready),
        .motion_update_enable (motion_update_enable),
        .out_data             (out_data),
        .out_data_dst_cell    (out_data_dst_cell),
        .out_data_valid       (out_data_valid),
        .busy                 (busy),
        .update_done          (update_done),
        .broadcast_count      (broadcast_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] data;
        logic [CW-1:0] dst;
    } xfer_t;

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] done;
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_ovalid;
    } vec_t;

    xfer_t              exp_q[$];
    vec_t               vecs[17];
    logic [PW-1:0]      cur_word[NUM_REQ];
    logic [CW-1:0]      cur_dst[NUM_REQ];
    int                 seq[NUM_REQ];
    bit [NUM_REQ-1:0]   adv;
    int                 n_checks;
    int                 n_fail;
    int                 n_xfer;
    bit                 mon_on;

    always_comb begin
        req_data     = '0;
        req_dst_cell = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*PW +: PW]     = cur_word[i];
            req_dst_cell[i*CW +: CW] = cur_dst[i];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] make_word(input int i, input int k);
        return {32'(k), 32'(i), 32'hC0DE_0000 + 32'(k)};
    endfunction

    function automatic logic [CW-1:0] make_dst(input int i, input int k);
        return {4'(i), 4'(k), 4'hA};
    endfunction

    // Advance to the next cycle; requesters granted last cycle present their
    // next word only after the edge that took the current one.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (adv[i]) begin
                adv[i]      = 1'b0;
                seq[i]      = seq[i] + 1;
                cur_word[i] = make_word(i, seq[i]);
                cur_dst[i]  = make_dst(i, seq[i]);
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_xfer = 0;
    endtask

    task automatic run_row(input string tag, input logic [NUM_REQ-1:0] v,
                           input logic [NUM_REQ-1:0] d, input logic [NUM_REQ-1:0] exp_ready);
        req_valid = v;
        req_done  = d;
        #1;
        check({tag, " req_ready"}, req_ready, exp_ready);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_ready[i]) begin
                exp_q.push_back({cur_word[i], cur_dst[i]});
                adv[i] = 1'b1;
                n_xfer++;
            end
        end
        tick();
    endtask

    // Called in the first SETTLE cycle; update_done is expected SETTLE cycles
    // later, followed by a return to IDLE.
    task automatic wait_done_pulse(input string tag);
        int k;
        k = -1;
        for (int c = 0; c < 20; c++) begin
            if (update_done === 1'b1) begin
                k = c;
                break;
            end
            check({tag, " enable low while settling"}, motion_update_enable, 1'b0);
            tick();
        end
        check({tag, " update_done delay"}, k, SETTLE);
        if (k >= 0) begin
            check({tag, " busy in DONE"}, busy, 1'b1);
            tick();
            check({tag, " update_done one cycle"}, update_done, 1'b0);
            check({tag, " idle after DONE"}, busy, 1'b0);
        end
    endtask

    // Scoreboard: every broadcast must match the oldest expected word, and
    // idle cycles must show zero data.
    always @(negedge clk) begin : monitor
        xfer_t e;
        if (mon_on) begin
            if (out_data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("out_data_valid with empty scoreboard", out_data_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_data_dst_cell", out_data_dst_cell, e.dst);
                end
            end else begin
                check("out_data_valid", out_data_valid, 1'b0);
                check("idle out_data zero", {out_data, out_data_dst_cell}, '0);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "simulation timed out");
    end

    initial begin : stim
        int pulses;

        // Arbitration vectors for the first pass (pointer starts at NUM_REQ-1).
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1};
        vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1};
        vecs[7]  = '{4'b1111, 4'b0000, 4'b1000, 1'b1};
        vecs[8]  = '{4'b0101, 4'b0000, 4'b0001, 1'b1};
        vecs[9]  = '{4'b0101, 4'b0000, 4'b0100, 1'b1};
        vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b1};
        vecs[11] = '{4'b1001, 4'b0000, 4'b1000, 1'b0};
        vecs[12] = '{4'b0010, 4'b0000, 4'b0010, 1'b1};
        vecs[13] = '{4'b0011, 4'b0000, 4'b0001, 1'b1};
        vecs[14] = '{4'b0011, 4'b0000, 4'b0010, 1'b1};
        vecs[15] = '{4'b1110, 4'b0000, 4'b0100, 1'b1};
        vecs[16] = '{4'b0000, 4'b1111, 4'b0000, 1'b1};

        n_checks = 0;
        n_fail   = 0;
        n_xfer   = 0;
        mon_on   = 1'b0;
        adv      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            seq[i]      = 0;
            cur_word[i] = make_word(i, 0);
            cur_dst[i]  = make_dst(i, 0);
        end

        // Reset with requests pending: nothing may be granted or driven.
        rst       = 1'b1;
        start     = 1'b0;
        req_valid = 4'b1111;
        req_done  = 4'b0000;
        tick();
        tick();
        mon_on = 1'b1;
        check("reset req_ready", req_ready, 4'b0000);
        check("reset enable", motion_update_enable, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset update_done", update_done, 1'b0);
        check("reset broadcast_count", broadcast_count, 16'd0);
        check("reset out_data_valid", out_data_valid, 1'b0);
        rst       = 1'b0;
        req_valid = 4'b0000;
        tick();
        check("idle req_ready", req_ready, 4'b0000);

        // Pass A: table-driven round-robin, continuous valid first.
        do_start();
        check("A count cleared", broadcast_count, 16'd0);
        for (int r = 0; r < 17; r++) begin
            check($sformatf("A row%0d enable", r), motion_update_enable, 1'b1);
            check($sformatf("A row%0d out_data_valid", r), out_data_valid, vecs[r].exp_ovalid);
            run_row($sformatf("A row%0d", r), vecs[r].valid, vecs[r].done, vecs[r].exp_ready);
        end
        req_done = 4'b0000;
        check("A enable fall", motion_update_enable, 1'b0);
        check("A busy in SETTLE", busy, 1'b1);
        wait_done_pulse("A");
        check("A broadcast_count", broadcast_count, n_xfer);

        // Pass B: requester 0 sends three words, then reports done.
        do_start();
        check("B count cleared", broadcast_count, 16'd0);
        for (int w = 0; w < 3; w++) begin
            cur_word[0] = PW'(w + 1);
            cur_dst[0]  = 12'h114;
            run_row($sformatf("B word%0d", w), 4'b0001, (w == 0) ? 4'b1110 : 4'b0000, 4'b0001);
        end
        check("B last broadcast under enable", motion_update_enable, 1'b1);
        check("B last out_data_valid", out_data_valid, 1'b1);
        run_row("B done", 4'b0000, 4'b0001, 4'b0000);
        check("B enable fall", motion_update_enable, 1'b0);
        wait_done_pulse("B");
        check("B broadcast_count", broadcast_count, 16'd3);

        // Pass C: requester 2 raises done together with its final word.
        do_start();
        run_row("C word0", 4'b0100, 4'b1011, 4'b0100);
        run_row("C word1+done", 4'b0100, 4'b0100, 4'b0100);
        check("C last broadcast under enable", motion_update_enable, 1'b1);
        check("C last out_data_valid", out_data_valid, 1'b1);
        run_row("C drain", 4'b0000, 4'b0000, 4'b0000);
        check("C enable fall", motion_update_enable, 1'b0);
        wait_done_pulse("C");
        check("C broadcast_count", broadcast_count, 16'd2);

        // Pass D: everyone done immediately, no data.
        do_start();
        check("D enable high", motion_update_enable, 1'b1);
        run_row("D all done", 4'b0000, 4'b1111, 4'b0000);
        req_done = 4'b0000;
        check("D enable one cycle", motion_update_enable, 1'b0);
        wait_done_pulse("D");
        check("D broadcast_count", broadcast_count, 16'd0);

        // Pass E: reset mid-RUN aborts without update_done.
        do_start();
        run_row("E word0", 4'b0011, 4'b1100, 4'b0001);
        run_row("E word1", 4'b0011, 4'b0000, 4'b0010);
        req_valid = 4'b0000;
        rst       = 1'b1;
        tick();
        check("E reset enable", motion_update_enable, 1'b0);
        check("E reset busy", busy, 1'b0);
        check("E reset update_done", update_done, 1'b0);
        check("E reset out_data_valid", out_data_valid, 1'b0);
        check("E reset out_data", out_data, '0);
        check("E reset broadcast_count", broadcast_count, 16'd0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("E no update_done after abort", update_done, 1'b0);
            check("E stays idle", busy, 1'b0);
            tick();
        end
        // Fresh pass: grant pointer must be back at NUM_REQ-1.
        do_start();
        run_row("E clean a", 4'b0110, 4'b1111, 4'b0010);
        run_row("E clean b", 4'b0100, 4'b0000, 4'b0100);
        check("E clean last under enable", motion_update_enable, 1'b1);
        run_row("E clean end", 4'b0000, 4'b0000, 4'b0000);
        check("E clean enable fall", motion_update_enable, 1'b0);
        wait_done_pulse("E");
        check("E broadcast_count", broadcast_count, 16'd2);

        // Pass F: start during SETTLE must be ignored.
        do_start();
        run_row("F all done", 4'b0000, 4'b1111, 4'b0000);
        req_done = 4'b0000;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (update_done === 1'b1) pulses++;
            check("F no restart", motion_update_enable, 1'b0);
            tick();
        end
        check("F update_done pulses", pulses, 1);
        check("F idle at end", busy, 1'b0);

        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
